// File: rtl/led_blink_array.sv
// Multi-channel LED driver: one shared tick prescaler feeding NUM_CH channels,
// each running OFF, ON, free-running BLINK or counted BURST.
module led_blink_array #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1_000,
  parameter int NUM_CH  = 4,
  parameter int PER_W   = 16,
  parameter int CNT_W   = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLOCK_100Mhz,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [PER_W-1:0]  cfg_half_per,
  input  logic [CNT_W-1:0]  cfg_burst,
  output logic              tick,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] busy
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_BURST = 2'b11
  } mode_e;

  logic [DIV_W-1:0] presc_q, presc_d;

  mode_e            mode_q   [NUM_CH];
  mode_e            mode_d   [NUM_CH];
  logic [PER_W-1:0] hp_q     [NUM_CH];
  logic [PER_W-1:0] hp_d     [NUM_CH];
  logic [PER_W-1:0] phase_q  [NUM_CH];
  logic [PER_W-1:0] phase_d  [NUM_CH];
  logic [CNT_W-1:0] pulses_q [NUM_CH];
  logic [CNT_W-1:0] pulses_d [NUM_CH];
  logic [NUM_CH-1:0] led_q, led_d;
  logic [NUM_CH-1:0] busy_q, busy_d;

  // With TICK_DIV=1 the count never leaves 0, so tick stays high.
  assign tick = (presc_q == DIV_W'(TICK_DIV - 1));

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  always_comb begin
    logic [PER_W-1:0] hp_eff;
    logic             expire;
    for (int i = 0; i < NUM_CH; i++) begin
      mode_d[i]   = mode_q[i];
      hp_d[i]     = hp_q[i];
      phase_d[i]  = phase_q[i];
      pulses_d[i] = pulses_q[i];
    end
    led_d  = led_q;
    busy_d = busy_q;
    hp_eff = '0;
    expire = 1'b0;

    for (int i = 0; i < NUM_CH; i++) begin
      hp_eff = (hp_q[i] == '0) ? PER_W'(1) : hp_q[i];
      expire = (phase_q[i] == hp_eff - PER_W'(1));

      // Out-of-range cfg_ch can never equal a valid index, so such writes fall through.
      if (cfg_we && (int'(cfg_ch) == i)) begin
        mode_d[i]   = mode_e'(cfg_mode);
        hp_d[i]     = cfg_half_per;
        phase_d[i]  = '0;
        pulses_d[i] = '0;
        busy_d[i]   = 1'b0;
        case (mode_e'(cfg_mode))
          MODE_OFF:   led_d[i] = 1'b0;
          MODE_ON:    led_d[i] = 1'b1;
          MODE_BLINK: led_d[i] = 1'b1;
          default: begin
            if (cfg_burst != '0) begin
              pulses_d[i] = cfg_burst;
              busy_d[i]   = 1'b1;
              led_d[i]    = 1'b1;
            end else begin
              mode_d[i] = MODE_OFF;
              led_d[i]  = 1'b0;
            end
          end
        endcase
      end else if (tick) begin
        case (mode_q[i])
          MODE_BLINK: begin
            if (expire) begin
              phase_d[i] = '0;
              led_d[i]   = ~led_q[i];
            end else begin
              phase_d[i] = phase_q[i] + PER_W'(1);
            end
          end
          MODE_BURST: begin
            if (expire) begin
              phase_d[i] = '0;
              if (led_q[i]) begin
                led_d[i]    = 1'b0;
                pulses_d[i] = pulses_q[i] - CNT_W'(1);
                // Last pulse ends the burst on the falling edge itself.
                if (pulses_q[i] == CNT_W'(1)) begin
                  mode_d[i] = MODE_OFF;
                  busy_d[i] = 1'b0;
                end
              end else begin
                led_d[i] = 1'b1;
              end
            end else begin
              phase_d[i] = phase_q[i] + PER_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_100Mhz or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      led_q   <= '0;
      busy_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i]   <= MODE_OFF;
        hp_q[i]     <= PER_W'(1);
        phase_q[i]  <= '0;
        pulses_q[i] <= '0;
      end
    end else begin
      presc_q <= presc_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i]   <= mode_d[i];
        hp_q[i]     <= hp_d[i];
        phase_q[i]  <= phase_d[i];
        pulses_q[i] <= pulses_d[i];
      end
    end
  end

  assign led  = led_q;
  assign busy = busy_q;

endmodule
